// File: rtl/kontroler_przerwan_if.sv
// ============================================================================
//  Module      : kontroler_przerwan_if
//  Description : CPU/peripheral-side bus of the priority interrupt controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface kontroler_przerwan_if #(
    parameter int LICZBA_ZRODEL = 8
);
    logic [7:0]               wartosc;
    logic                     zapisz_ctr;
    logic                     zapisz_maska;
    logic                     zapisz_clear;
    logic [LICZBA_ZRODEL-1:0] irq_in;
    logic                     int_req;
    logic [7:0]               int_adres;
    logic                     int_ack;
    logic                     int_koniec;
    logic [LICZBA_ZRODEL-1:0] oczekujace;
    logic                     w_obsludze;

    modport master (
        output wartosc, zapisz_ctr, zapisz_maska, zapisz_clear, irq_in,
        output int_ack, int_koniec,
        input  int_req, int_adres, oczekujace, w_obsludze
    );

    modport slave (
        input  wartosc, zapisz_ctr, zapisz_maska, zapisz_clear, irq_in,
        input  int_ack, int_koniec,
        output int_req, int_adres, oczekujace, w_obsludze
    );
endinterface

`default_nettype wire

// File: rtl/kontroler_przerwan.sv
// ============================================================================
//  Module      : kontroler_przerwan
//  Description : Fixed-priority (lowest index first) interrupt controller with
//                pending/mask/enable registers and ack/RETI handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module kontroler_przerwan #(
    parameter int         LICZBA_ZRODEL = 8,
    parameter logic [7:0] WEKTOR_BAZA   = 8'h04
) (
    input  wire logic          clk,
    input  wire logic          rst,
    kontroler_przerwan_if.slave bus
);

    localparam int c_SZER_IDX = 3;

    typedef enum logic [1:0] {
        BEZCZYNNY = 2'd0,
        ZADANIE   = 2'd1,
        OBSLUGA   = 2'd2
    } stan_t;

    stan_t                    r_stan;
    stan_t                    w_stan_nast;
    logic [LICZBA_ZRODEL-1:0] r_maska;
    logic                     r_wlacz;
    logic [LICZBA_ZRODEL-1:0] r_oczekujace;
    logic [c_SZER_IDX-1:0]    r_indeks;
    logic [7:0]               r_adres;
    logic                     r_int_req;
    logic                     r_w_obsludze;

    logic [LICZBA_ZRODEL-1:0] w_uprawnione;
    logic [LICZBA_ZRODEL-1:0] w_kasuj;
    logic [LICZBA_ZRODEL-1:0] w_oczekujace_nast;
    logic [c_SZER_IDX-1:0]    w_wygrany;
    logic                     w_zatrzask;
    logic                     w_ack_ok;
    logic                     w_clear_wygrywa;

    assign w_uprawnione    = r_oczekujace & r_maska & {LICZBA_ZRODEL{r_wlacz}};
    assign w_clear_wygrywa = bus.zapisz_clear & ~bus.zapisz_ctr & ~bus.zapisz_maska;

    // Scan downwards so the lowest eligible index is the last to assign.
    always_comb begin
        w_wygrany = '0;
        for (int i = LICZBA_ZRODEL - 1; i >= 0; i--) begin
            if (w_uprawnione[i]) begin
                w_wygrany = c_SZER_IDX'(i);
            end
        end
    end

    always_comb begin
        w_stan_nast = r_stan;
        w_zatrzask  = 1'b0;
        w_ack_ok    = 1'b0;
        case (r_stan)
            BEZCZYNNY: begin
                if (|w_uprawnione) begin
                    w_stan_nast = ZADANIE;
                    w_zatrzask  = 1'b1;
                end
            end
            ZADANIE: begin
                if (bus.int_ack) begin
                    w_stan_nast = OBSLUGA;
                    w_ack_ok    = 1'b1;
                end else if (!w_uprawnione[r_indeks]) begin
                    w_stan_nast = BEZCZYNNY;
                end
            end
            OBSLUGA: begin
                if (bus.int_koniec) begin
                    w_stan_nast = BEZCZYNNY;
                end
            end
            default: w_stan_nast = BEZCZYNNY;
        endcase
    end

    // A new event in the same cycle as its clear keeps the bit set.
    always_comb begin
        w_kasuj = '0;
        if (w_ack_ok) begin
            w_kasuj[r_indeks] = 1'b1;
        end
        if (w_clear_wygrywa) begin
            w_kasuj = w_kasuj | bus.wartosc[LICZBA_ZRODEL-1:0];
        end
        w_oczekujace_nast = (r_oczekujace & ~w_kasuj) | bus.irq_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stan       <= BEZCZYNNY;
            r_maska      <= '0;
            r_wlacz      <= 1'b0;
            r_oczekujace <= '0;
            r_indeks     <= '0;
            r_adres      <= '0;
            r_int_req    <= 1'b0;
            r_w_obsludze <= 1'b0;
        end else begin
            r_stan       <= w_stan_nast;
            r_oczekujace <= w_oczekujace_nast;
            if (bus.zapisz_ctr) begin
                r_wlacz <= bus.wartosc[7];
            end else if (bus.zapisz_maska) begin
                r_maska <= bus.wartosc[LICZBA_ZRODEL-1:0];
            end
            if (w_zatrzask) begin
                r_indeks <= w_wygrany;
                r_adres  <= WEKTOR_BAZA + {3'b000, w_wygrany, 2'b00};
            end
            r_int_req    <= (w_stan_nast == ZADANIE);
            r_w_obsludze <= (w_stan_nast == OBSLUGA);
        end
    end

    assign bus.int_req    = r_int_req;
    assign bus.int_adres  = r_adres;
    assign bus.oczekujace = r_oczekujace;
    assign bus.w_obsludze = r_w_obsludze;

endmodule

`default_nettype wire

// File: doc/kontroler_przerwan.md
# kontroler_przerwan

Priority interrupt controller that sits between the processor's interrupt-generating peripherals (counter/timer, future UART, GPIO) and the CPU core. It latches single-cycle interrupt pulses from up to eight sources into a pending register, applies a software-programmable mask and global enable, and presents one request at a time to the CPU with a fixed-priority vector. It then tracks the acknowledge / end-of-service handshake; the CPU cannot nest interrupts.

## Interface

- LICZBA_ZRODEL, 8, number of interrupt sources (1..8); unused bits of the byte registers read 0 and ignore writes.
- WEKTOR_BAZA, 8'h04, base address of the vector table; entries are 4 bytes apart.

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wartosc  in  8  data byte for register writes.
- zapisz_ctr  in  1  write control register:
  - bit7 = global enable;
  - other bits ignored.
- zapisz_maska  in  1  write mask register; bit i = 1 enables source i.
- zapisz_clear  in  1  write-1-to-clear pending bits from wartosc.
- irq_in  in  LICZBA_ZRODEL  interrupt pulses from peripherals; each high cycle is one event.
- int_req  out  1  request to CPU.
- int_adres  out  8  vector address = WEKTOR_BAZA + 4*index, valid while int_req = 1.
- int_ack  in  1  CPU accepts the current request.
- int_koniec  in  1  CPU finished the handler (RETI).
- oczekujace  out  LICZBA_ZRODEL  pending register, readable for polling.
- w_obsludze  out  1  a handler is in service.

## Operation

- Pending bit i is set on any cycle with irq_in[i] = 1, regardless of mask or enable. Masked events are kept for polling.
- Pending bit i is cleared by:
  - int_ack for the source being served;
  - zapisz_clear with wartosc[i] = 1.
- If a set and a clear hit the same bit in the same cycle, set wins: the bit stays 1.
- Eligible set = oczekujace & maska, gated by global enable. The highest priority goes to the lowest index.
- Register writes have priority zapisz_ctr > zapisz_maska > zapisz_clear when more than one is asserted; only the winner takes effect.
- State machine:
  - BEZCZYNNY: if the eligible set is non-empty, latch the winner's index and go to ZADANIE.
  - ZADANIE: int_req = 1 with the latched int_adres. The latched index is frozen; a higher-priority arrival does not change it.
    - int_ack: clear pending[index], go to OBSLUGA.
    - Otherwise, if the latched source is no longer eligible (cleared, masked, or global enable = 0), go to BEZCZYNNY with no service.
    - int_ack wins over withdrawal in the same cycle.
  - OBSLUGA: w_obsludze = 1, int_req = 0. New events accumulate as pending. int_koniec → BEZCZYNNY.
- int_ack outside ZADANIE and int_koniec outside OBSLUGA are ignored.
- Index arithmetic: int_adres = WEKTOR_BAZA + {index, 2'b00}, 8-bit modulo-256 wrap.

## Timing

- Reset values, all registered:
  - int_req = 0, int_adres = 0, w_obsludze = 0, oczekujace = 0;
  - mask = 0, global enable = 0, state BEZCZYNNY.
- Reset in any state returns to these values after one edge. No request survives reset.
- All outputs are registered.
- Event latency:
  - irq_in[i] high in cycle n → oczekujace[i] = 1 in cycle n+1.
  - int_req = 1 in cycle n+2, if eligible and in BEZCZYNNY.
- int_ack in cycle m → in cycle m+1: int_req = 0, w_obsludze = 1, and pending bit cleared.
- int_koniec in cycle k → w_obsludze = 0 in cycle k+1. The earliest next int_req is cycle k+2.
- Register writes take effect at the next edge. A mask written in cycle n affects arbitration from cycle n+1.
- Withdrawal: the eligibility loss is registered at edge n. int_req = 0 in cycle n+2.

## Test plan

- Reset, then enable (ctr = 8'h80, maska = 8'h01), pulse irq_in[0] one cycle → int_req = 1 two cycles later, int_adres = 8'h04; ack → w_obsludze = 1, oczekujace = 0.
- Pulses on irq_in[5] and irq_in[2] in the same cycle, maska = 8'hFF → int_adres = 8'h0C first. After ack + koniec, the next request has int_adres = 8'h18.
- While in ZADANIE for source 3, pulse irq_in[1] → int_adres stays 8'h10. After koniec, source 1 is served (8'h08).
- maska = 0, pulse irq_in[4] → no int_req, oczekujace = 8'h10. Then zapisz_clear with 8'h10 → oczekujace = 0.
- In ZADANIE for source 0, write maska = 0 → int_req drops, state BEZCZYNNY, oczekujace[0] still 1. Repeat with int_ack in the same cycle as the mask write → service proceeds.
- int_ack for source 2 in the same cycle as irq_in[2] → OBSLUGA entered and oczekujace[2] = 1. Assert rst during OBSLUGA → all outputs 0 next cycle.
